// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
//   Shared definitions for the pipelined carry-lookahead subtractor.
//   - CLA_WIDTH_DEFAULT : default operand width of cla_sub_pipe
//   - sub_result_t      : packed {diff, bout, ovf} result at the default width
//   - ovf_sub()         : signed-overflow rule for a - b (- borrow)
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int CLA_WIDTH_DEFAULT = 32;
    localparam int CLA_HALF_DEFAULT  = CLA_WIDTH_DEFAULT / 2;

    typedef struct packed {
        logic [CLA_WIDTH_DEFAULT-1:0] diff;
        logic                         bout;
        logic                         ovf;
    } sub_result_t;

    // Subtraction overflows only when the operands have different signs and
    // the result's sign differs from the minuend's sign.
    function automatic logic ovf_sub(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla.sv
// -----------------------------------------------------------------------------
// cla
//   Purely combinational carry-lookahead adder: sum_o = a_i + b_i + cin_i.
//   Ports:
//     a_i, b_i  in  WIDTH  addends
//     cin_i     in  1      carry in
//     sum_o     out WIDTH  sum modulo 2^WIDTH
//     cout_o    out 1      carry out of the top bit
// -----------------------------------------------------------------------------
module cla #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] gen;
    logic [WIDTH-1:0] prop;
    logic [WIDTH:0]   carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Carry into bit i+1 as a flat sum of products:
    //   c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
    // Each carry is derived directly from g/p/cin, so no carry waits
    // on a lower one.
    function automatic logic lookahead(input logic [WIDTH-1:0] g_v,
                                       input logic [WIDTH-1:0] p_v,
                                       input logic             c_v,
                                       input int               top);
        logic res;
        logic run_p;
        res   = 1'b0;
        run_p = 1'b1;
        for (int j = top; j >= 0; j--) begin
            res   = res | (g_v[j] & run_p);
            run_p = run_p & p_v[j];
        end
        return res | (c_v & run_p);
    endfunction

    assign carry[0] = cin_i;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
            assign carry[gi+1] = lookahead(gen, prop, cin_i, gi);
        end
    endgenerate

    assign sum_o  = prop ^ carry[WIDTH-1:0];
    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/cla_sub_pipe.sv
// -----------------------------------------------------------------------------
// cla_sub_pipe
//   Two-stage pipelined subtractor: diff = a - b - bin, with borrow-out and
//   signed overflow. Computed as a + ~b + ~bin on two half-width CLAs: the
//   low half resolves in stage 1 and its carry feeds the high half in stage 2.
//   Valid/ready on both sides, one result per cycle when not back-pressured.
//   WIDTH must be even and >= 8.
//   Ports:
//     clk        in   1      clock
//     rst        in   1      asynchronous reset, active-high
//     in_valid   in   1      a/b/bin valid
//     in_ready   out  1      operands accepted this cycle
//     a, b       in   WIDTH  minuend, subtrahend
//     bin        in   1      borrow in
//     out_valid  out  1      diff/bout/ovf valid
//     out_ready  in   1      consumer takes the result
//     diff       out  WIDTH  (a - b - bin) mod 2^WIDTH
//     bout       out  1      unsigned borrow out
//     ovf        out  1      signed overflow
// -----------------------------------------------------------------------------
module cla_sub_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int H = WIDTH / 2;

    // Stage 1 state: low-half result plus the high-half operands it needs.
    logic         s1_valid_q, s1_valid_d;
    logic [H-1:0] lo_sum_q;
    logic         lo_carry_q;
    logic [H-1:0] a_hi_q;
    logic [H-1:0] nb_hi_q;

    // Stage 2 state: the visible result.
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;

    // Combinational stage outputs.
    logic [H-1:0]     lo_sum_d;
    logic             lo_carry_d;
    logic [H-1:0]     hi_sum_d;
    logic             hi_cout_d;
    logic [WIDTH-1:0] diff_d;
    logic             bout_d;
    logic             ovf_d;

    logic in_fire;
    logic out_fire;
    logic s2_adv;

    // Stage 1 adder: a - b - bin == a + ~b + ~bin (low half).
    cla #(.WIDTH(H)) u_cla_lo (
        .a_i    (a[H-1:0]),
        .b_i    (~b[H-1:0]),
        .cin_i  (~bin),
        .sum_o  (lo_sum_d),
        .cout_o (lo_carry_d)
    );

    // Stage 2 adder: high half, continuing from the registered low carry.
    cla #(.WIDTH(H)) u_cla_hi (
        .a_i    (a_hi_q),
        .b_i    (nb_hi_q),
        .cin_i  (lo_carry_q),
        .sum_o  (hi_sum_d),
        .cout_o (hi_cout_d)
    );

    assign diff_d = {hi_sum_d, lo_sum_q};
    // A carry out of a + ~b + ~bin means no borrow was needed.
    assign bout_d = ~hi_cout_d;
    assign ovf_d  = ovf_sub(a_hi_q[H-1], ~nb_hi_q[H-1], hi_sum_d[H-1]);

    // Handshake. in_ready sees out_ready through s2_adv; that path is the
    // price of full throughput with only two result slots.
    assign s2_adv   = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_adv;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = s2_valid_q && out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        if (s2_adv) begin
            s2_valid_d = 1'b1;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    // Data registers load only on their stage's transfer, so operand values
    // presented without in_valid never reach the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            lo_sum_q   <= '0;
            lo_carry_q <= 1'b0;
            a_hi_q     <= '0;
            nb_hi_q    <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_fire) begin
                lo_sum_q   <= lo_sum_d;
                lo_carry_q <= lo_carry_d;
                a_hi_q     <= a[WIDTH-1:H];
                nb_hi_q    <= ~b[WIDTH-1:H];
            end
            if (s2_adv) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_sub_pipe.sv
module tb_cla_sub_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b1;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       bin8 = 1'b0, bout8, ovf8;
    // 64-bit instance
    logic        in_valid64 = 1'b0, in_ready64, out_valid64, out_ready64 = 1'b1;
    logic [63:0] a64 = '0, b64 = '0, diff64;
    logic        bin64 = 1'b0, bout64, ovf64;

    cla_sub_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    cla_sub_pipe #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .a(a64), .b(b64), .bin(bin64), .out_valid(out_valid64), .out_ready(out_ready64),
        .diff(diff64), .bout(bout64), .ovf(ovf64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model from arithmetic: {ovf, bout, diff} for a w-bit a - b - bin.
    // bout: the exact unsigned difference is negative. ovf: the exact signed
    // difference falls outside the w-bit two's complement range.
    function automatic logic [65:0] model(input int w, input logic [63:0] ma,
                                          input logic [63:0] mb, input logic mbin);
        logic [63:0]        mask;
        logic [64:0]        full;
        logic signed [65:0] sa, sb, r, hi, lo;
        mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        full = {1'b0, ma & mask} - {1'b0, mb & mask} - {64'd0, mbin};
        sa = $signed({2'b00, ma & mask});
        if (ma[w-1]) sa = sa - (66'sd1 <<< w);
        sb = $signed({2'b00, mb & mask});
        if (mb[w-1]) sb = sb - (66'sd1 <<< w);
        r  = sa - sb - $signed({65'd0, mbin});
        hi = (66'sd1 <<< (w - 1)) - 66'sd1;
        lo = -(66'sd1 <<< (w - 1));
        return {(r > hi) || (r < lo), full[64], full[63:0] & mask};
    endfunction

    // Scoreboards: expected results queued on input fire, checked on output fire.
    logic [65:0] q8[$];
    logic [65:0] q64[$];
    int          pops8 = 0, pops64 = 0;
    logic        held8 = 1'b0, held64 = 1'b0;
    logic [65:0] hold8, hold64;

    always @(negedge clk) begin
        if (rst) begin
            q8.delete();
            held8 = 1'b0;
        end else begin
            if (held8) begin
                chk("w8 hold valid", {65'd0, out_valid8}, 66'd1);
                chk("w8 hold data", {ovf8, bout8, 56'd0, diff8}, hold8);
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    chk("w8 spurious out_valid", 66'd1, 66'd0);
                end else begin
                    logic [65:0] e;
                    e = q8.pop_front();
                    $display("[w8] result %0d: diff=%h bout=%b ovf=%b", pops8, diff8, bout8, ovf8);
                    chk("w8 result", {ovf8, bout8, 56'd0, diff8}, e);
                    pops8++;
                end
            end
            held8 = out_valid8 && !out_ready8;
            hold8 = {ovf8, bout8, 56'd0, diff8};
            if (in_valid8 && in_ready8)
                q8.push_back(model(8, {56'd0, a8}, {56'd0, b8}, bin8));
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q64.delete();
            held64 = 1'b0;
        end else begin
            if (held64) begin
                chk("w64 hold valid", {65'd0, out_valid64}, 66'd1);
                chk("w64 hold data", {ovf64, bout64, diff64}, hold64);
            end
            if (out_valid64 && out_ready64) begin
                if (q64.size() == 0) begin
                    chk("w64 spurious out_valid", 66'd1, 66'd0);
                end else begin
                    logic [65:0] e;
                    e = q64.pop_front();
                    $display("[w64] result %0d: diff=%h bout=%b ovf=%b", pops64, diff64, bout64, ovf64);
                    chk("w64 result", {ovf64, bout64, diff64}, e);
                    pops64++;
                end
            end
            held64 = out_valid64 && !out_ready64;
            hold64 = {ovf64, bout64, diff64};
            if (in_valid64 && in_ready64)
                q64.push_back(model(64, a64, b64, bin64));
        end
    end

    // One operation on an idle pipe; checks the result literally two cycles later.
    task automatic op(input int w, input logic [63:0] ta, input logic [63:0] tbv, input logic tbin,
                      input logic [65:0] exp, input string name);
        @(posedge clk); #1;
        if (w == 8) begin in_valid8 = 1'b1; a8 = ta[7:0]; b8 = tbv[7:0]; bin8 = tbin; end
        else        begin in_valid64 = 1'b1; a64 = ta; b64 = tbv; bin64 = tbin; end
        @(posedge clk); #1;
        in_valid8 = 1'b0; in_valid64 = 1'b0;
        chk({name, " valid at N+1"}, {65'd0, (w == 8) ? out_valid8 : out_valid64}, 66'd0);
        @(posedge clk); #1;
        if (w == 8) begin
            chk({name, " valid at N+2"}, {65'd0, out_valid8}, 66'd1);
            chk(name, {ovf8, bout8, 56'd0, diff8}, exp);
        end else begin
            chk({name, " valid at N+2"}, {65'd0, out_valid64}, 66'd1);
            chk(name, {ovf64, bout64, diff64}, exp);
        end
    endtask

    task automatic rand_run(input int w, input int nops);
        int acc = 0;
        int cyc = 0;
        int drain = 0;
        while (acc < nops && cyc < 60000) begin
            @(posedge clk); #1;
            if (w == 8) begin
                in_valid8  = ($urandom_range(3) != 0);
                out_ready8 = ($urandom_range(2) != 0);
                a8 = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
                b8 = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
                bin8 = 1'($urandom);
            end else begin
                in_valid64  = ($urandom_range(3) != 0);
                out_ready64 = ($urandom_range(2) != 0);
                a64 = ($urandom_range(7) == 0) ? 64'd0 : {$urandom, $urandom};
                b64 = ($urandom_range(7) == 0) ? {64{1'b1}} : {$urandom, $urandom};
                bin64 = 1'($urandom);
            end
            @(negedge clk);
            if (w == 8) begin if (in_valid8 && in_ready8) acc++; end
            else begin if (in_valid64 && in_ready64) acc++; end
            cyc++;
        end
        @(posedge clk); #1;
        if (w == 8) begin in_valid8 = 1'b0; out_ready8 = 1'b1; end
        else begin in_valid64 = 1'b0; out_ready64 = 1'b1; end
        chk((w == 8) ? "w8 random ops accepted" : "w64 random ops accepted", 66'(acc), 66'(nops));
        while (((w == 8) ? q8.size() : q64.size()) != 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #1;
        chk((w == 8) ? "w8 drain" : "w64 drain", 66'((w == 8) ? q8.size() : q64.size()), 66'd0);
    endtask

    initial begin
        int p0;

        // The model itself, pinned against hand-computed results.
        chk("model 0xCA-0x65", model(8, 64'hCA, 64'h65, 1'b0), {1'b1, 1'b0, 64'h65});
        chk("model 0x00-0x01", model(8, 64'h00, 64'h01, 1'b0), {1'b0, 1'b1, 64'hFF});
        chk("model 0x7F-0xFF", model(8, 64'h7F, 64'hFF, 1'b0), {1'b1, 1'b1, 64'h80});
        chk("model 64b 0-0-1", model(64, 64'd0, 64'd0, 1'b1), {1'b0, 1'b1, {64{1'b1}}});

        // Reset state.
        #12;
        chk("reset out_valid", {64'd0, out_valid8, out_valid64}, 66'd0);
        chk("reset in_ready", {64'd0, in_ready8, in_ready64}, 66'd3);
        chk("reset w8 data", {ovf8, bout8, 56'd0, diff8}, 66'd0);
        chk("reset w64 data", {ovf64, bout64, diff64}, 66'd0);
        @(posedge clk); #1 rst = 1'b0;

        // -54 - 101 = -155 is below -128, so signed overflow is set.
        op(8,  64'hCA, 64'h65, 1'b0, {1'b1, 1'b0, 64'h65}, "w8 basic CA-65");
        op(8,  64'h00, 64'h01, 1'b0, {1'b0, 1'b1, 64'hFF}, "w8 borrow 00-01");
        op(8,  64'h80, 64'h80, 1'b1, {1'b0, 1'b1, 64'hFF}, "w8 borrow 80-80-1");
        op(8,  64'h80, 64'h01, 1'b0, {1'b1, 1'b0, 64'h7F}, "w8 ovf 80-01");
        op(8,  64'h7F, 64'hFF, 1'b0, {1'b1, 1'b1, 64'h80}, "w8 ovf 7F-FF");
        op(64, 64'd0,  64'd0,  1'b1, {1'b0, 1'b1, {64{1'b1}}}, "w64 borrow 0-0-1");
        op(64, 64'h8000_0000_0000_0000, 64'd1, 1'b0, {1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF}, "w64 ovf min-1");
        op(64, 64'h0000_0001_0000_0000, 64'd1, 1'b0, {1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF}, "w64 half carry");

        // Backpressure: out_ready low for three cycles while four ops stream in.
        repeat (3) @(posedge clk);
        p0 = pops8;
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'h10; b8 = 8'h03; bin8 = 1'b0;
        @(negedge clk); chk("bp in_ready c0", {65'd0, in_ready8}, 66'd1);
        @(posedge clk); #1;
        out_ready8 = 1'b0; a8 = 8'h05; b8 = 8'h09;
        @(negedge clk); chk("bp in_ready c1", {65'd0, in_ready8}, 66'd1);
        @(posedge clk); #1;
        a8 = 8'h20; b8 = 8'h01; bin8 = 1'b1;
        @(negedge clk);
        chk("bp in_ready full", {65'd0, in_ready8}, 66'd0);
        chk("bp first result", {out_valid8, ovf8, bout8, 55'd0, diff8}, {1'b1, 1'b0, 1'b0, 63'h0D});
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp in_ready still full", {65'd0, in_ready8}, 66'd0);
        chk("bp diff held", {58'd0, diff8}, 66'h0D);
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        @(negedge clk); chk("bp in_ready release", {65'd0, in_ready8}, 66'd1);
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b0;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("bp results delivered", 66'(pops8 - p0), 66'd4);

        // Reset with two ops in flight.
        @(posedge clk); #1;
        in_valid8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
        @(posedge clk); #1;
        a8 = 8'h44; b8 = 8'h22;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid reset out_valid", {65'd0, out_valid8}, 66'd0);
        chk("mid reset diff", {58'd0, diff8}, 66'd0);
        chk("mid reset in_ready", {65'd0, in_ready8}, 66'd1);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("no stale result", {65'd0, out_valid8}, 66'd0);
        end

        // Random traffic on both widths concurrently.
        fork
            rand_run(8, 10000);
            rand_run(64, 10000);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
